// File: rtl/mem_access.sv
// mem_access: MEM-stage SRAM access sequencer.
// Runs a load or store against an asynchronous SRAM and holds the pipeline
// (stallreq_o) until the access has finished. WAIT_CYCLES (1..7) sets how
// many cycles the read access or the write strobe lasts.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   memAddr_i, rMem_i, wMem_i     access request from EX/MEM
//   wData_i, wReg_i, wRegAddr_i   ALU result / store data, write-back control
//   stallreq_o                    freeze request to the pipeline controller
//   wData_o, wReg_o, wRegAddr_o   write-back to MEM/WB
//   ram_addr_o, ram_data_o        SRAM address and write data
//   ram_data_oe                   1 = this block drives the SRAM data bus
//   ram_data_i                    SRAM read data
//   ram_ce_n, ram_oe_n, ram_we_n  SRAM strobes, active-low
//
// state    | meaning
// IDLE     | no access; pass ALU results through, watch for requests
// RD_WAIT  | CE/OE asserted, waiting WAIT_CYCLES, then sample read data
// RD_DONE  | strobes released, captured data delivered to write-back
// WR_SETUP | address/data driven, WE still high (setup time)
// WR_PULSE | WE low for WAIT_CYCLES cycles
// WR_DONE  | WE released, address/data held one cycle (hold time)

module mem_access #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] memAddr_i,
  input  logic        rMem_i,
  input  logic        wMem_i,
  input  logic [15:0] wData_i,
  input  logic        wReg_i,
  input  logic [3:0]  wRegAddr_i,
  output logic        stallreq_o,
  output logic [15:0] wData_o,
  output logic        wReg_o,
  output logic [3:0]  wRegAddr_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_data_o,
  output logic        ram_data_oe,
  input  logic [15:0] ram_data_i,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_DONE
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // A load wins over a simultaneous store; the store is dropped.
        if (rMem_i) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_INIT;
        end else if (wMem_i) begin
          state_d = WR_SETUP;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = ram_data_i;
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_DONE:  state_d = IDLE;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_INIT;
      end
      WR_PULSE: begin
        if (cnt_q == 3'd0) state_d = WR_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      WR_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so an async reset of
  // the state releases them in the same cycle, including mid write pulse.
  always_comb begin
    stallreq_o  = 1'b0;
    ram_ce_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_data_oe = 1'b0;
    ram_addr_o  = 16'h0000;
    ram_data_o  = 16'h0000;
    case (state_q)
      IDLE:    stallreq_o = rMem_i | wMem_i;
      RD_WAIT: begin
        stallreq_o = 1'b1;
        ram_ce_n   = 1'b0;
        ram_oe_n   = 1'b0;
        ram_addr_o = memAddr_i;
      end
      WR_SETUP, WR_PULSE: begin
        stallreq_o  = 1'b1;
        ram_ce_n    = 1'b0;
        ram_we_n    = (state_q != WR_PULSE);
        ram_data_oe = 1'b1;
        ram_addr_o  = memAddr_i;
        ram_data_o  = wData_i;
      end
      WR_DONE: begin
        ram_ce_n    = 1'b0;
        ram_data_oe = 1'b1;
        ram_addr_o  = memAddr_i;
        ram_data_o  = wData_i;
      end
      default: ;
    endcase
  end

  assign wData_o    = (state_q == RD_DONE) ? rdata_q : wData_i;
  assign wReg_o     = wReg_i & ~stallreq_o;
  assign wRegAddr_o = wRegAddr_i;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: one instance with WAIT_CYCLES=1, one with 3.
// Expected write-back values and strobe/stall cycle counts are queued when an
// operation is driven and popped when the DUT drops its stall request.

module tb_mem_access;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_addr [2];
  logic        r_mem  [2];
  logic        w_mem  [2];
  logic [15:0] w_data [2];
  logic        w_reg  [2];
  logic [3:0]  w_ra   [2];
  logic [15:0] ram_din[2];
  logic        stall  [2];
  logic [15:0] wdo    [2];
  logic        wro    [2];
  logic [3:0]  wrao   [2];
  logic [15:0] raddr  [2];
  logic [15:0] rdout  [2];
  logic        doe    [2];
  logic        ce_n   [2];
  logic        oe_n   [2];
  logic        we_n   [2];

  mem_access #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .memAddr_i(m_addr[0]), .rMem_i(r_mem[0]),
    .wMem_i(w_mem[0]), .wData_i(w_data[0]), .wReg_i(w_reg[0]),
    .wRegAddr_i(w_ra[0]), .stallreq_o(stall[0]), .wData_o(wdo[0]),
    .wReg_o(wro[0]), .wRegAddr_o(wrao[0]), .ram_addr_o(raddr[0]),
    .ram_data_o(rdout[0]), .ram_data_oe(doe[0]), .ram_data_i(ram_din[0]),
    .ram_ce_n(ce_n[0]), .ram_oe_n(oe_n[0]), .ram_we_n(we_n[0]));

  mem_access #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .memAddr_i(m_addr[1]), .rMem_i(r_mem[1]),
    .wMem_i(w_mem[1]), .wData_i(w_data[1]), .wReg_i(w_reg[1]),
    .wRegAddr_i(w_ra[1]), .stallreq_o(stall[1]), .wData_o(wdo[1]),
    .wReg_o(wro[1]), .wRegAddr_o(wrao[1]), .ram_addr_o(raddr[1]),
    .ram_data_o(rdout[1]), .ram_data_oe(doe[1]), .ram_data_i(ram_din[1]),
    .ram_ce_n(ce_n[1]), .ram_oe_n(oe_n[1]), .ram_we_n(we_n[1]));

  typedef struct {
    logic [15:0] data;
    logic        wreg;
    logic [3:0]  wra;
    int          stall_cyc;
    int          oe_cyc;
    int          we_cyc;
    int          doe_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle(input int d);
    m_addr[d] = 16'h0; r_mem[d] = 1'b0; w_mem[d] = 1'b0;
    w_data[d] = 16'h0; w_reg[d] = 1'b0; w_ra[d] = 4'h0;
    ram_din[d] = 16'h0;
  endtask

  // Called just after a negedge; returns just after the negedge following
  // completion with the request removed.
  task automatic run_op(input int d, input int w, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] dat,
                        input logic wreg, input logic [3:0] wra,
                        input logic [15:0] rin, input string tag);
    exp_t e;
    int st = 0, oe = 0, we = 0, de = 0, bad = 0, n = 0;
    bit done = 1'b0;
    m_addr[d] = a; r_mem[d] = rd; w_mem[d] = wr; w_data[d] = dat;
    w_reg[d] = wreg; w_ra[d] = wra; ram_din[d] = rin;
    e.wra = wra;
    e.wreg = wreg;
    if (rd) begin
      e.data = rin; e.stall_cyc = 1 + w; e.oe_cyc = w; e.we_cyc = 0; e.doe_cyc = 0;
    end else if (wr) begin
      e.data = dat; e.stall_cyc = 2 + w; e.oe_cyc = 0; e.we_cyc = w; e.doe_cyc = w + 2;
    end else begin
      e.data = dat; e.stall_cyc = 0; e.oe_cyc = 0; e.we_cyc = 0; e.doe_cyc = 0;
    end
    sb.push_back(e);
    while (!done && n < 40) begin
      #1;
      if (stall[d]) st++;
      if (!oe_n[d]) oe++;
      if (!we_n[d]) we++;
      if (doe[d]) de++;
      if (stall[d] && wro[d]) bad++;
      if (!oe_n[d] && doe[d]) bad++;
      if (!ce_n[d] && raddr[d] !== a) bad++;
      if (doe[d] && rdout[d] !== dat) bad++;
      if (ce_n[d] && (raddr[d] !== 16'h0 || rdout[d] !== 16'h0)) bad++;
      if (!stall[d]) begin
        done = 1'b1;
        e = sb.pop_front();
        chk({tag, "_wdata"}, 32'(wdo[d]), 32'(e.data));
        chk({tag, "_wreg"},  32'(wro[d]), 32'(e.wreg));
        chk({tag, "_wra"},   32'(wrao[d]), 32'(e.wra));
      end else begin
        @(negedge clk);
      end
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_cyc"}, st, e.stall_cyc);
    chk({tag, "_oe_cyc"}, oe, e.oe_cyc);
    chk({tag, "_we_cyc"}, we, e.we_cyc);
    chk({tag, "_doe_cyc"}, de, e.doe_cyc);
    chk({tag, "_bus_rule"}, bad, 0);
    @(negedge clk);
    set_idle(d);
  endtask

  initial begin
    int lows;
    set_idle(0);
    set_idle(1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ce_n", 32'(ce_n[d]), 32'd1);
      chk("rst_oe_n", 32'(oe_n[d]), 32'd1);
      chk("rst_we_n", 32'(we_n[d]), 32'd1);
      chk("rst_doe",  32'(doe[d]), 32'd0);
      chk("rst_stall", 32'(stall[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES = 1
    run_op(0, 1, 1, 0, 16'h1234, 16'hDEAD, 1'b1, 4'h3, 16'hBEEF, "w1_load");
    run_op(0, 1, 0, 0, 16'h0000, 16'h0042, 1'b1, 4'h5, 16'h0000, "w1_alu");
    run_op(0, 1, 1, 1, 16'h2222, 16'h7777, 1'b1, 4'h9, 16'h5A5A, "w1_rdwr");
    run_op(0, 1, 1, 0, 16'h0010, 16'h0000, 1'b1, 4'h1, 16'h1111, "w1_b2b_a");
    run_op(0, 1, 1, 0, 16'h0011, 16'h0000, 1'b1, 4'h2, 16'h2222, "w1_b2b_b");
    run_op(0, 1, 0, 1, 16'h00A0, 16'h3C3C, 1'b0, 4'h0, 16'h0000, "w1_store");

    // WAIT_CYCLES = 3
    run_op(1, 3, 0, 1, 16'h8000, 16'h00FF, 1'b0, 4'h0, 16'h0000, "w3_store");
    run_op(1, 3, 1, 0, 16'h4321, 16'h0BAD, 1'b1, 4'hE, 16'hCAFE, "w3_load");
    run_op(1, 3, 0, 0, 16'h0000, 16'h9876, 1'b1, 4'h7, 16'h0000, "w3_alu");

    // Reset in the middle of the write pulse
    m_addr[1] = 16'h8000; w_mem[1] = 1'b1; w_data[1] = 16'h1357;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_wr_pulse_on", 32'(we_n[1]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wr_we_n", 32'(we_n[1]), 32'd1);
    chk("rst_wr_doe",  32'(doe[1]), 32'd0);
    chk("rst_wr_ce_n", 32'(ce_n[1]), 32'd1);
    set_idle(1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (!we_n[1] || doe[1] || stall[1] || !ce_n[1]) lows++;
    end
    chk("rst_no_retry", lows, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
